pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 19 +
 rtl/pipe_skid_reg.sv | 119 +++++++++++
 tb/tb_pipe_skid_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-register definitions.
//
// Holds the occupancy-state encoding used by every skid-buffered pipeline
// register (IF/ID, ID/EX, EX/MEM). The numeric value of each state is the
// number of entries the stage holds, so occupancy is a direct decode.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // no entry held
        ST_FULL  = 2'd1,   // main entry only
        ST_SKID  = 2'd2    // main and skid entries
    } skid_state_t;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_count(input skid_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with hold, flush and a
// saturating count of upstream-blocked cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers in_data
//   in_data    upstream payload (DATA_W)
//   in_ready   stage accepts in_data this cycle
//   out_valid  out_data is valid
//   out_data   downstream payload (DATA_W), always the main entry
//   out_ready  downstream accepts out_data
//   hold       hazard stall: freezes state and payloads, blocks both sides
//   flush      squash: empties the stage and loads FLUSH_VAL, beats hold
//   occupancy  number of held entries (0..2)
//   stall_cnt  saturating count of cycles with in_valid=1 and in_ready=0
//
// in_ready depends only on registered state, hold and flush, so there is
// no combinational path from out_ready back to upstream.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_t       state, state_next;
    logic [DATA_W-1:0] main_q, main_next;
    logic [DATA_W-1:0] skid_q, skid_next;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              in_fire, out_fire;

    assign in_ready  = (state != ST_SKID) && !hold && !flush;
    assign out_valid = (state != ST_EMPTY) && !hold;
    assign out_data  = main_q;
    assign occupancy = state_count(state);
    assign stall_cnt = stall_cnt_q;

    // hold forces both ready and valid low, so neither fire can happen
    // while stalled and the case below naturally leaves everything as-is.
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            main_q <= FLUSH_VAL;
            skid_q <= FLUSH_VAL;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = ST_EMPTY;
            main_next  = FLUSH_VAL;
            skid_next  = FLUSH_VAL;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_FULL;
                        main_next  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (out_fire) begin
                        // main keeps the delivered value; it is simply no longer valid
                        state_next = ST_EMPTY;
                    end else if (in_fire) begin
                        state_next = ST_SKID;
                        skid_next  = in_data;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_next = ST_FULL;
                        main_next  = skid_q;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Counts every cycle upstream is blocked, including hold and flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !in_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int          DW   = 16;
    localparam logic [15:0] FVAL = 16'hDEAD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          hold;
    logic          flush;

    logic          in_ready,  s_in_ready;
    logic          out_valid, s_out_valid;
    logic [DW-1:0] out_data,  s_out_data;
    logic [1:0]    occupancy, s_occupancy;
    logic [15:0]   stall_cnt;
    logic [1:0]    s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO of held entries plus the last head value.
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_head;
    logic [15:0]   m_cnt16;
    logic [1:0]    m_cnt2;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FVAL), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .hold(hold), .flush(flush),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FVAL), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(out_ready), .hold(hold), .flush(flush),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_head = FVAL;
        m_cnt16   = '0;
        m_cnt2    = '0;
    endtask

    // One clock: drive at the falling edge, check outputs 1ns later, then
    // advance the model to what the next rising edge should produce.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic h, input logic f);
        logic e_in_ready, e_out_valid, fi, fo;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        hold      = h;
        flush     = f;
        #1;
        e_in_ready  = (q.size() < 2) && !h && !f;
        e_out_valid = (q.size() > 0) && !h;
        check("in_ready",    in_ready,    e_in_ready);
        check("out_valid",   out_valid,   e_out_valid);
        check("out_data",    out_data,    last_head);
        check("occupancy",   occupancy,   q.size());
        check("stall_cnt",   stall_cnt,   m_cnt16);
        check("s_in_ready",  s_in_ready,  e_in_ready);
        check("s_out_valid", s_out_valid, e_out_valid);
        check("s_out_data",  s_out_data,  last_head);
        check("s_occupancy", s_occupancy, q.size());
        check("s_stall_cnt", s_stall_cnt, m_cnt2);

        if (iv && !e_in_ready) begin
            if (m_cnt16 != 16'hFFFF) m_cnt16++;
            if (m_cnt2 != 2'd3)      m_cnt2++;
        end
        if (f) begin
            q.delete();
            last_head = FVAL;
        end else begin
            fi = iv && e_in_ready;
            fo = e_out_valid && ordy;
            if (fo) last_head = q.pop_front();
            if (fi) q.push_back(d);
            if (q.size() > 0) last_head = q[0];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_out_data",  out_data,  FVAL);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        rst_n = 1'b1;

        // Stream: one in, one out every cycle
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Backpressure: fill both entries, stay blocked, then drain
        step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        check("bp_occupancy", occupancy, 2'd2);
        check("bp_sat_cnt",   s_stall_cnt, 2'd3);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while in SKID with 0xC offered
        step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h000C, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("fl_out_data", out_data, FVAL);
        idle(1);

        // Hold: FULL with 0x5, frozen for 3 cycles, then released
        step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0006, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h0006, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Asynchronous reset mid-cycle while holding two entries
        step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid,   1'b0);
        check("arst_occupancy", occupancy,   2'd0);
        check("arst_out_data",  out_data,    FVAL);
        check("arst_stall_cnt", stall_cnt,   16'd0);
        check("arst_sat_cnt",   s_stall_cnt, 2'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 70), DW'($urandom),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
